// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle between a producer, one elastic pipeline stage and its consumer.
// Carries both transfer sides plus flush and the stage status outputs.
// master = the environment around the stage, slave = the stage itself.
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with flush and saturating stall counter; PIPE_SKID_EN adds a skid entry.
// Latency: one falling clk edge from acceptance to out_data/out_valid.
// Backpressure: skid build absorbs one beat and deasserts a registered in_ready; otherwise in_ready = !out_valid || out_ready.
module pipe_stage_elastic #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipe_stage_elastic_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] main_q;
    logic              out_valid_q;
    logic [1:0]        occupancy_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic              acc;
    logic              take;

    assign acc  = bus.in_valid && bus.in_ready;
    assign take = out_valid_q && bus.out_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.occupancy = occupancy_q;
    assign bus.stall_cnt = stall_cnt_q;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_q;
    logic              in_ready_q;

    // in_ready comes straight from a flop so there is no path from out_ready to in_ready.
    assign bus.in_ready = in_ready_q;

    // Three-state stage FSM (EMPTY/ONE/TWO) with status outputs registered alongside the state.
    always_ff @(negedge clk) begin
        if (reset || bus.flush) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_q      <= bus.in_data;
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                        occupancy_q <= 2'd1;
                    end
                end
                ST_ONE: begin
                    if (acc && take) begin
                        main_q <= bus.in_data;
                    end else if (acc) begin
                        // Consumer stalled while the producer pushed: park the beat in skid.
                        skid_q      <= bus.in_data;
                        state_q     <= ST_TWO;
                        in_ready_q  <= 1'b0;
                        occupancy_q <= 2'd2;
                    end else if (take) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                        occupancy_q <= 2'd0;
                    end
                end
                ST_TWO: begin
                    if (take) begin
                        main_q      <= skid_q;
                        state_q     <= ST_ONE;
                        in_ready_q  <= 1'b1;
                        occupancy_q <= 2'd1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    occupancy_q <= 2'd0;
                end
            endcase
        end
    end
`else
    // Single entry: a full stage can still accept when the consumer drains it this cycle.
    assign bus.in_ready = !out_valid_q || bus.out_ready;

    // Two-state stage FSM (EMPTY/ONE) with status outputs registered alongside the state.
    always_ff @(negedge clk) begin
        if (reset || bus.flush) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_q      <= bus.in_data;
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                        occupancy_q <= 2'd1;
                    end
                end
                ST_ONE: begin
                    // In ONE an accept implies a take, so the entry is simply replaced.
                    if (acc) begin
                        main_q <= bus.in_data;
                    end else if (take) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                        occupancy_q <= 2'd0;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    occupancy_q <= 2'd0;
                end
            endcase
        end
    end
`endif

    // Count cycles where valid data is held back by the consumer; saturate, ignore flush cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !bus.out_ready && !bus.flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register; only reset clears it.
    always_ff @(negedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
